// File: rtl/alu_pkg.sv
// Shared opcode table, sequencer FSM encoding and command layout for the ALU path.
// Latency: none (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_ADDA = 4'b0100;
    localparam logic [3:0] OP_MULA = 4'b0101;
    localparam logic [3:0] OP_MAC  = 4'b0110;
    localparam logic [3:0] OP_ROL  = 4'b0111;
    localparam logic [3:0] OP_ROR  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_ETH  = 4'b1101;
    localparam logic [3:0] OP_GTH  = 4'b1110;
    localparam logic [3:0] OP_LTH  = 4'b1111;

    // Sequencer FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    // One queued command: 4-bit opcode plus two 8-bit operands (20 bits).
    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Opcodes that modify the ALU's internal accumulator when sampled.
    function automatic logic is_accum_op(input logic [3:0] op);
        return (op == OP_ADDA) || (op == OP_MULA) || (op == OP_MAC);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue: synchronous FIFO with flush, power-of-two DEPTH entries of WIDTH bits.
// Latency: written entry is visible at the read port one cycle after the push edge.
// Backpressure: full blocks pushes (no overwrite); empty blocks pops; flush beats a same-edge push.
//
// Ports: clk, rst_n (async, active-low); wr_vld/wr_dat push side; rd_vld pop request,
//        rd_dat head entry; flush discards all entries; full/empty status.
module alu_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = wr_vld && !full;
    assign do_pop  = rd_vld && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands and issues them one at a time to an external ALU, returning each result.
// Latency: command into empty queue at edge E0 -> rsp_valid after edge E(2+ALU_LATENCY).
// Backpressure: cmd_ready = queue not full; RESP holds its result until rsp_ready, stalling issue.
//
// Ports: clk, rst_n (async, active-low);
//        cmd_valid/cmd_ready/cmd_opcode/cmd_a/cmd_b  command input;
//        flush                                        drop queued, unissued commands;
//        alu_a/alu_b/alu_opcode -> ALU, alu_out <- ALU;
//        rsp_valid/rsp_ready/rsp_data/rsp_opcode     result output;
//        busy                                         queue non-empty or command in flight.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ALU_LATENCY = 1,
    parameter logic [3:0]  IDLE_OPCODE = OP_AND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_opcode,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       flush,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_opcode,
    output logic       busy
);

    localparam logic [2:0] WAIT_LAST = 3'(ALU_LATENCY - 1);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [2:0] wait_cnt_q;
    logic [2:0] wait_cnt_d;

    // Low in reset and for the first edge after release so the queue never
    // takes a command while the rest of the block is still coming out of reset.
    logic       run_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_push;
    logic [CMD_W-1:0] fifo_rd_dat;
    cmd_t             in_cmd;
    cmd_t             head;

    logic             head_avail;
    logic             issue;
    logic             capture;

    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [3:0] alu_op_q;
    logic [3:0] cur_op_q;
    logic [7:0] rsp_data_q;
    logic [3:0] rsp_op_q;

    assign in_cmd    = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
    assign head      = cmd_t'(fifo_rd_dat);
    assign cmd_ready = run_q && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (fifo_push),
        .wr_dat (in_cmd),
        .rd_vld (fifo_pop),
        .rd_dat (fifo_rd_dat),
        .flush  (flush),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A flush on this edge empties the queue, so the head is not issuable.
    assign head_avail = !fifo_empty && !flush;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fifo_pop   = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (head_avail) begin
                    fifo_pop = 1'b1;
                    issue    = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Single cycle: the ALU sees this command on exactly one edge.
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    capture    = 1'b1;
                    state_d    = ST_RESP;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (head_avail) begin
                        fifo_pop = 1'b1;
                        issue    = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            run_q      <= 1'b1;
        end
    end

    // ALU drive registers: loaded only for the ISSUE cycle, otherwise parked
    // on the non-accumulating idle opcode with zero operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= IDLE_OPCODE;
            cur_op_q <= 4'h0;
        end else if (issue) begin
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            alu_op_q <= head.opcode;
            cur_op_q <= head.opcode;
        end else begin
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= IDLE_OPCODE;
        end
    end

    // Result registers change only on capture, so they are stable through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= 8'h00;
            rsp_op_q   <= 4'h0;
        end else if (capture) begin
            rsp_data_q <= alu_out;
            rsp_op_q   <= cur_op_q;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_opcode = rsp_op_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU with accumulator, response scoreboard, directed + random steps.
// Latency: n/a.
// Backpressure: rsp_ready driven by the bench, both directed stalls and random.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_opcode = 4'h0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       flush = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [3:0] rsp_opcode;
    logic       busy;

    always #5 clk = ~clk;

    alu_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .ALU_LATENCY (LAT),
        .IDLE_OPCODE (OP_AND)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .flush      (flush),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_opcode (rsp_opcode),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    int rsp_count = 0;
    int acc_count = 0;
    int cnt_adda = 0;
    int cnt_mac  = 0;
    logic [11:0] exp_q [$];
    logic [7:0]  ref_acc = 8'h00;
    logic [7:0]  alu_acc = 8'h00;
    logic [7:0]  alu_pipe [LAT] = '{default: 8'h00};
    logic        prev_stall = 1'b0;
    logic [11:0] prev_rsp = 12'h000;
    logic [3:0]  na_ops [6] = '{OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_ROL, OP_NAND};

    // ---------------- ALU behaviour (opcode table arithmetic) ----------------
    function automatic logic [7:0] alu_acc_next(input logic [3:0] op, input logic [7:0] a,
                                                input logic [7:0] b, input logic [7:0] acc);
        if (!is_accum_op(op)) return acc;
        case (op)
            OP_ADDA: return acc + a;
            OP_MULA: return 8'(acc * a);
            default: return acc + 8'(a * b);
        endcase
    endfunction

    function automatic logic [7:0] alu_res(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] acc);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return 8'(a * b);
            OP_DIV:  return (b == 8'h00) ? 8'hFF : a / b;
            OP_ADDA, OP_MULA, OP_MAC: return alu_acc_next(op, a, b, acc);
            OP_ROL:  return {a[6:0], a[7]};
            OP_ROR:  return {a[0], a[7:1]};
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_ETH:  return (a == b) ? 8'd1 : 8'd0;
            OP_GTH:  return (a > b) ? 8'd1 : 8'd0;
            OP_LTH:  return (a < b) ? 8'd1 : 8'd0;
            default: return 8'h00;
        endcase
    endfunction

    // External ALU: samples its inputs every edge, result appears LAT edges later.
    // Its accumulator is independent of the sequencer reset.
    always @(posedge clk) begin
        alu_pipe[0] <= alu_res(alu_opcode, alu_a, alu_b, alu_acc);
        alu_acc     <= alu_acc_next(alu_opcode, alu_a, alu_b, alu_acc);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
        if (alu_opcode == OP_ADDA) cnt_adda <= cnt_adda + 1;
        if (alu_opcode == OP_MAC)  cnt_mac  <= cnt_mac + 1;
    end
    assign alu_out = alu_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: accepted commands -> ordered expected results ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready && !flush) begin
                exp_q.push_back({cmd_opcode, alu_res(cmd_opcode, cmd_a, cmd_b, ref_acc)});
                ref_acc = alu_acc_next(cmd_opcode, cmd_a, cmd_b, ref_acc);
                acc_count++;
            end
            if (prev_stall) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_value", {rsp_opcode, rsp_data}, prev_rsp);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    chk("rsp_opcode", rsp_opcode, e[11:8]);
                    chk("rsp_data", rsp_data, e[7:0]);
                end
                rsp_count++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rsp   = {rsp_opcode, rsp_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("send_ready", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rsp_ready = 1'b1;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_empty"}, exp_q.size(), 0);
    endtask

    function automatic logic [3:0] pick_na();
        return na_ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        int          r0;
        int          c0;
        int          a_cnt;
        int          m_cnt;
        int          n;
        logic [7:0]  acc0;
        logic [11:0] held;

        // ---- reset values, asserted asynchronously ----
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_opcode", rsp_opcode, 4'h0);
        chk("rst_alu_opcode", alu_opcode, OP_AND);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // ---- single ADD, latency and issue window ----
        rsp_ready = 1'b1;
        send(OP_ADD, 8'h0A, 8'h05);
        chk("add_busy", busy, 1);
        tick();
        chk("add_issue_opcode", alu_opcode, OP_ADD);
        chk("add_issue_a", alu_a, 8'h0A);
        chk("add_issue_b", alu_b, 8'h05);
        tick();
        chk("add_idle_opcode", alu_opcode, OP_AND);
        chk("add_idle_a", alu_a, 8'h00);
        for (int k = 0; k < LAT; k++) begin
            chk("add_not_yet_valid", rsp_valid, 0);
            tick();
        end
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_rsp_data", rsp_data, 8'h0F);
        chk("add_rsp_opcode", rsp_opcode, OP_ADD);
        tick();
        chk("add_done_valid", rsp_valid, 0);
        chk("add_done_busy", busy, 0);

        // ---- stall: 1 in flight + DEPTH queued, extra offer ignored ----
        rsp_ready = 1'b0;
        r0 = rsp_count;
        c0 = acc_count;
        for (int i = 0; i < DEPTH + 1; i++) send(pick_na(), 8'($urandom), 8'($urandom));
        repeat (LAT + 3) tick();
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_accepted", acc_count - c0, DEPTH + 1);
        chk("full_rsp_valid", rsp_valid, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = OP_SUB;
        cmd_a      = 8'h77;
        cmd_b      = 8'h11;
        repeat (4) tick();
        cmd_valid  = 1'b0;
        chk("full_no_accept", acc_count - c0, DEPTH + 1);
        held = {rsp_opcode, rsp_data};
        repeat (3) tick();
        chk("stall_rsp_stable", {rsp_opcode, rsp_data}, held);
        chk("stall_no_rsp", rsp_count - r0, 0);
        drain("stall");
        chk("stall_rsp_total", rsp_count - r0, DEPTH + 1);

        // ---- accumulating ops reach the ALU exactly once each ----
        acc0  = alu_acc;
        a_cnt = cnt_adda;
        m_cnt = cnt_mac;
        send(OP_ADDA, 8'h03, 8'h00);
        send(OP_MAC, 8'h02, 8'h04);
        drain("accum");
        chk("adda_sample_count", cnt_adda - a_cnt, 1);
        chk("mac_sample_count", cnt_mac - m_cnt, 1);
        chk("accum_value", alu_acc, 8'(acc0 + 8'd11));

        // ---- flush during first command's WAIT ----
        r0 = rsp_count;
        send(OP_ADD, 8'($urandom), 8'($urandom));
        send(OP_XOR, 8'($urandom), 8'($urandom));
        send(OP_OR, 8'($urandom), 8'($urandom));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        drain("flush");
        chk("flush_one_rsp", rsp_count - r0, 1);
        repeat (10) tick();
        chk("flush_no_extra", rsp_count - r0, 1);
        chk("flush_busy", busy, 0);
        chk("flush_cmd_ready", cmd_ready, 1);

        // ---- reset pulse during WAIT ----
        r0 = rsp_count;
        send(OP_SUB, 8'h40, 8'h01);
        send(OP_AND, 8'hF0, 8'h3C);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_alu_opcode", alu_opcode, OP_AND);
        chk("midrst_alu_a", alu_a, 8'h00);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (15) tick();
        chk("midrst_no_rsp", rsp_count - r0, 0);
        chk("midrst_busy_after", busy, 0);
        chk("midrst_ready_after", cmd_ready, 1);

        // ---- simultaneous push and pop with 3 queued ----
        rsp_ready = 1'b0;
        r0 = rsp_count;
        for (int i = 0; i < 4; i++) send(pick_na(), 8'($urandom), 8'($urandom));
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("pp_rsp_valid", rsp_valid, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = OP_NAND;
        cmd_a      = 8'($urandom);
        cmd_b      = 8'($urandom);
        rsp_ready  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        rsp_ready  = 1'b0;
        chk("pp_ready_at_3", cmd_ready, 1);
        send(OP_ROL, 8'($urandom), 8'($urandom));
        chk("pp_full_at_4", cmd_ready, 0);
        drain("pp");
        chk("pp_rsp_total", rsp_count - r0, 6);

        // ---- random traffic over all opcodes ----
        r0 = rsp_count;
        c0 = acc_count;
        for (int i = 0; i < 400; i++) begin
            cmd_valid  = ($urandom_range(0, 99) < 60);
            cmd_opcode = 4'($urandom);
            cmd_a      = 8'($urandom);
            cmd_b      = 8'($urandom);
            rsp_ready  = ($urandom_range(0, 99) < 50);
            tick();
        end
        cmd_valid = 1'b0;
        drain("rand");
        chk("rand_rsp_count", rsp_count - r0, acc_count - c0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
